// File: rtl/fetch_unit.sv
// In-order fetch with a DEPTH-slot request/response queue, redirect flushing; FETCH_PERF_EN adds perf counters.
// First instruction reaches decode 2 cycles after the first request; inst_ready low holds the head and stops issue once full.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned DW  = 8;
  localparam int unsigned DSW = DW + 1;
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      slot_pc_q   [DEPTH];
  logic [31:0]      slot_pc_d   [DEPTH];
  logic [31:0]      slot_data_q [DEPTH];
  logic [31:0]      slot_data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    used_q, used_d, pend_q, pend_d;
  logic [DW-1:0]    drop_q, drop_d;
  logic [DW:0]      drop_sum;
  logic             req_fire, pop, rsp_fill, unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign imem_req_valid   = (state_q == RUN) && (used_q < C_FULL) && !redirect_valid;
  assign imem_req_addr    = pc_current;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign inst_valid       = filled_q[head_q];
  assign inst_data        = slot_data_q[head_q];
  assign inst_pc          = slot_pc_q[head_q];
  assign pop              = inst_valid && inst_ready;
  assign rsp_fill         = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);

  always_comb begin
    if (redirect_valid)  pc_next = {redirect_pc[31:2], 2'b00};
    else if (req_fire)   pc_next = pc_current + 32'd4;
    else                 pc_next = pc_current;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    slot_pc_d   = slot_pc_q;
    slot_data_d = slot_data_q;
    filled_d    = filled_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    used_d      = used_q;
    pend_d      = pend_q;
    drop_sum    = {1'b0, drop_q};
    if (redirect_valid) begin
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      used_d   = '0;
      pend_d   = '0;
      // Every unfilled slot becomes junk in flight; a response landing now is one of those.
      drop_sum = {1'b0, drop_q} + DSW'(pend_q) - DSW'(imem_rsp_valid);
    end else begin
      if (imem_rsp_valid && (drop_q != '0)) drop_sum = {1'b0, drop_q} - DSW'(1);
      if (rsp_fill) begin
        slot_data_d[fill_q] = imem_rsp_data;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + P_ONE;
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + P_ONE;
      end
      if (req_fire) begin
        slot_pc_d[tail_q] = pc_current;
        tail_d            = tail_q + P_ONE;
      end
      used_d = used_q + CW'(req_fire) - CW'(pop);
      pend_d = pend_q + CW'(req_fire) - CW'(rsp_fill);
    end
    drop_d = drop_sum[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      used_q   <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_pc_q   <= slot_pc_d;
      slot_data_q <= slot_data_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      used_q      <= used_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop && !redirect_valid);
    perf_stall_d   = perf_stall_q + 32'((state_q == RUN) && !inst_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_rsp_orphan: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> ((pend_q != '0) || (drop_q != '0)))
    else $error("fetch_unit: response with no unfilled slot and no drop pending");
  a_drop_ovf: assert property (@(posedge clk) disable iff (!rst) !drop_sum[DW])
    else $error("fetch_unit: drop count overflow");
  a_boot_pc: assert property (@(posedge clk) disable iff (!rst)
    (state_q == BOOT) |-> (pc_current == RESET_PC))
    else $error("fetch_unit: pc register not at RESET_PC after reset");
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: owns the pc register and an in-order memory, checks against a slot-queue model.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_current, pc_next, imem_req_addr, imem_rsp_data, redirect_pc, inst_data, inst_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, inst_valid, inst_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_current(pc_current), .pc_next(pc_next),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] pc_reg;
  assign pc_current = pc_reg;
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= RESET_PC;
    else      pc_reg <= pc_next;
  end

  typedef struct packed {logic [31:0] pc; logic [31:0] data; logic filled;} ent_t;
  typedef struct packed {logic [31:0] data; logic [31:0] due;} mrsp_t;

  ent_t        mq[$];
  mrsp_t       memq[$];
  logic [31:0] pops[$];
  int          drop_m = 0;
  bit          m_run = 0;
  int          cyc = 0, lat = 1, p_rdy = 100, p_irdy = 100, p_redir = 0;
  bit          redir_now = 0;
  logic [31:0] redir_tgt = '0;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pops.size()) ? pops[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare current outputs to the model, then advance the model by the coming edge.
  bit          exp_rv, fire_m, exp_iv, pop_m, done;
  logic [31:0] exp_nx;
  int          unf;
  ent_t        e;
  mrsp_t       mr;
  always @(negedge clk) begin
    if (rst) begin
      exp_rv = m_run && (mq.size() < DEPTH) && !redirect_valid;
      fire_m = exp_rv && imem_req_ready;
      exp_nx = redirect_valid ? {redirect_pc[31:2], 2'b00} : (fire_m ? pc_current + 32'd4 : pc_current);
      exp_iv = (mq.size() > 0) && mq[0].filled;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("req_addr", imem_req_addr, pc_current);
      chk("pc_next", pc_next, exp_nx);
      chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv) begin
        chk("inst_pc", inst_pc, mq[0].pc);
        chk("inst_data", inst_data, mq[0].data);
      end
      pop_m = exp_iv && inst_ready;
      if (imem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        mr.data = mem_word(imem_req_addr);
        mr.due  = 32'(cyc + lat);
        memq.push_back(mr);
      end
      if (imem_rsp_valid) begin
        if (drop_m > 0) drop_m--;
        else begin
          done = 0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!done && !mq[i].filled) begin
              e = mq[i]; e.filled = 1'b1; e.data = imem_rsp_data; mq[i] = e; done = 1;
            end
          end
        end
      end
      if (redirect_valid) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        drop_m += unf;
        mq.delete();
      end else begin
        if (pop_m) begin
          pops.push_back(mq[0].pc);
          void'(mq.pop_front());
        end
        if (fire_m) begin
          e.pc = pc_current; e.data = '0; e.filled = 1'b0;
          mq.push_back(e);
        end
      end
      m_run = 1;
    end
  end

  task automatic drive();
    cyc++;
    imem_req_ready = (int'($urandom_range(99)) < p_rdy);
    inst_ready     = (int'($urandom_range(99)) < p_irdy);
    if (redir_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_now      = 0;
    end else begin
      redirect_valid = (int'($urandom_range(99)) < p_redir);
      redirect_pc    = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFF);
    end
    imem_rsp_valid = (memq.size() > 0) && (int'(memq[0].due) <= cyc);
    imem_rsp_data  = imem_rsp_valid ? memq[0].data : $urandom;
  endtask

  task automatic step();
    @(posedge clk); #1; drive();
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk); #1; rst = 1'b1; drive();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  bit          have, found;
  logic [31:0] hpc, hdat;
  initial begin
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);

    // Boot and sequential stream with a 1-cycle memory
    release_rst(); at_neg();
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    step(); at_neg();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    step(); step(); at_neg();
    chk("first_inst_valid", 32'(inst_valid), 32'd1);
    chk("first_inst_pc", inst_pc, 32'h0);
    chk("first_inst_data", inst_data, 32'hBEEF_FFFF);
    step_n(12);
    for (int i = 0; i < 4; i++) chk("a_pop_seq", pop_at(i), 32'(4 * i));

    // Decode stalls: queue fills, head holds
    p_irdy = 0; have = 0;
    for (int i = 0; i < 6; i++) begin
      step(); at_neg();
      if (inst_valid) begin
        if (have) begin
          chk("b_hold_pc", inst_pc, hpc);
          chk("b_hold_data", inst_data, hdat);
        end
        have = 1; hpc = inst_pc; hdat = inst_data;
      end
    end
    chk("b_full_no_req", 32'(imem_req_valid), 32'd0);
    chk("b_full_pc_hold", pc_next, pc_current);
    p_irdy = 100;
    step_n(10);
    chk("b_pop_count", 32'(pops.size() >= 8), 32'd1);
    for (int i = 0; i < pops.size(); i++) chk("b_no_loss", pops[i], 32'(4 * i));

    // Memory not ready at 0x10
    redir_now = 1; redir_tgt = 32'h10;
    step(); pops.delete(); at_neg();
    chk("c_redir_no_req", 32'(imem_req_valid), 32'd0);
    chk("c_redir_pc_next", pc_next, 32'h10);
    p_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step(); at_neg();
      chk("c_stall_valid", 32'(imem_req_valid), 32'd1);
      chk("c_stall_addr", imem_req_addr, 32'h10);
      chk("c_stall_pc_next", pc_next, 32'h10);
    end
    p_rdy = 100;
    step(); at_neg();
    chk("c_resume_addr", imem_req_addr, 32'h10);
    chk("c_resume_pc_next", pc_next, 32'h14);
    step_n(8);
    chk("c_first_pop", pop_at(0), 32'h10);

    // Redirect to the top of the address space and wrap
    redir_now = 1; redir_tgt = 32'hFFFF_FFFF;
    step(); at_neg();
    chk("w_redir_pc_next", pc_next, 32'hFFFF_FFFC);
    step(); at_neg();
    chk("w_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("w_wrap_pc_next", pc_next, 32'h0);
    step(); at_neg();
    chk("w_wrapped_addr", imem_req_addr, 32'h0);

    // 3-cycle memory, two in flight, redirect drops both
    lat = 3; redir_now = 1; redir_tgt = 32'h20;
    step(); step(); step();
    redir_now = 1; redir_tgt = 32'h103;
    step(); pops.delete(); at_neg();
    chk("d_redir_no_req", 32'(imem_req_valid), 32'd0);
    chk("d_redir_pc_next", pc_next, 32'h100);
    step(); at_neg();
    chk("d_req_valid", 32'(imem_req_valid), 32'd1);
    chk("d_req_addr", imem_req_addr, 32'h100);
    step_n(14);
    chk("d_first_pop", pop_at(0), 32'h100);

    // Redirect coinciding with a response and a decode pop
    lat = 1;
    step_n(6);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (inst_valid && imem_rsp_valid && inst_ready && !redirect_valid) begin
        redirect_valid = 1'b1; redirect_pc = 32'h200; found = 1;
      end
    end
    chk("e_coincide_found", 32'(found), 32'd1);
    pops.delete();
    step(); at_neg();
    chk("e_no_spurious_valid", 32'(inst_valid), 32'd0);
    chk("e_req_addr", imem_req_addr, 32'h200);
    step_n(10);
    chk("e_pop0", pop_at(0), 32'h200);
    chk("e_pop1", pop_at(1), 32'h204);

    // Asynchronous reset mid-stream with responses pending
    lat = 3;
    step_n(5);
    @(posedge clk); #3; rst = 1'b0; #1;
    chk_zero("midrst");
    memq.delete(); mq.delete(); pops.delete(); drop_m = 0; m_run = 0;
    repeat (2) @(posedge clk);
    release_rst(); at_neg();
    chk("f_boot_no_req", 32'(imem_req_valid), 32'd0);
    step(); at_neg();
    chk("f_req_valid", 32'(imem_req_valid), 32'd1);
    chk("f_req_addr", imem_req_addr, RESET_PC);
    step_n(12);
    chk("f_first_pop", pop_at(0), RESET_PC);

    // Randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      lat     = int'($urandom_range(3, 1));
      p_rdy   = int'($urandom_range(100, 40));
      p_irdy  = int'($urandom_range(100, 30));
      p_redir = int'($urandom_range(10, 0));
      step_n(300);
    end
    p_redir = 0; p_rdy = 100; p_irdy = 100;
    step_n(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
